// File: rtl/ext_mem_model_mc.sv
// Multi-channel byte-addressed memory model for HLS benches: per-channel
// request FSM with independent read/write latency, backdoor preload, sticky errors.
module ext_mem_model_mc #(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int SIZE_W      = 6,
  parameter int MEMSIZE     = 128,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic [7:0]               init_data,
  output logic                     err_both,
  output logic                     err_range
);

  localparam int NB_MAX  = DATA_W / 8;
  localparam int MEM_AW  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int MEM_END = BASE_ADDR + MEMSIZE;
  localparam logic [3:0] RD_CNT = 4'(READ_DELAY - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [7:0]          mem_q [MEMSIZE];

  state_e              state_q [N_CH];
  state_e              state_d [N_CH];
  logic [3:0]          cnt_q   [N_CH];
  logic [3:0]          cnt_d   [N_CH];
  logic [DATA_W-1:0]   hold_q  [N_CH];
  logic [DATA_W-1:0]   hold_d  [N_CH];
  logic [N_CH*DATA_W-1:0] rdata_q, rdata_d;
  logic [N_CH-1:0]     rdy_q, rdy_d;
  logic                err_both_q, err_range_q;
  logic                both_hit, range_hit;

  logic [N_CH-1:0]     wr_acc;
  logic [MEM_AW-1:0]   wr_off [N_CH];
  int                  wr_nb  [N_CH];
  logic                init_hit;
  logic [MEM_AW-1:0]   init_off;

  // NOTE: every signal and local written here gets a default before any
  // conditional assignment, so no path can leave a value held (no latch).
  always_comb begin
    int                a;
    int                sz;
    int                nb;
    logic              oe;
    logic              we;
    logic              in_rng;
    logic              out_all;
    logic [DATA_W-1:0] rd_val;

    a = 0; sz = 0; nb = 0; oe = 1'b0; we = 1'b0;
    in_rng = 1'b0; out_all = 1'b0; rd_val = '0;
    both_hit  = 1'b0;
    range_hit = 1'b0;
    rdy_d     = '0;
    rdata_d   = '0;

    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      hold_d[c]  = hold_q[c];
      wr_acc[c]  = 1'b0;
      wr_off[c]  = '0;
      wr_nb[c]   = 0;

      a  = int'(Mout_addr_ram[c*ADDR_W +: ADDR_W]);
      sz = int'(Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
      if (sz == 0 || sz > DATA_W) sz = DATA_W;
      nb = (sz < 8) ? 1 : sz / 8;
      oe = Mout_oe_ram[c];
      we = Mout_we_ram[c];

      in_rng  = (a >= BASE_ADDR) && (a + nb <= MEM_END);
      out_all = (a + nb <= BASE_ADDR) || (a >= MEM_END);

      if (oe && we) both_hit = 1'b1;
      if ((oe || we) && !in_rng && !out_all) range_hit = 1'b1;

      // Read capture sees the array as it was before this edge's writes.
      rd_val = '0;
      for (int j = 0; j < NB_MAX; j++) begin
        if (in_rng && j < nb) rd_val[j*8 +: 8] = mem_q[MEM_AW'(a - BASE_ADDR + j)];
      end

      unique case (state_q[c])
        S_IDLE: begin
          if ((oe ^ we) && in_rng) begin
            hold_d[c]  = oe ? rd_val : '0;
            cnt_d[c]   = oe ? RD_CNT : WR_CNT;
            state_d[c] = (cnt_d[c] == 4'd0) ? S_RESP : S_WAIT;
            if (we) begin
              wr_acc[c] = 1'b1;
              wr_off[c] = MEM_AW'(a - BASE_ADDR);
              wr_nb[c]  = nb;
            end
          end
        end
        S_WAIT: begin
          cnt_d[c] = cnt_q[c] - 4'd1;
          if (cnt_d[c] == 4'd0) state_d[c] = S_RESP;
        end
        S_RESP:  state_d[c] = S_IDLE;
        default: state_d[c] = S_IDLE;
      endcase

      if (state_d[c] == S_RESP) begin
        rdy_d[c]                     = 1'b1;
        rdata_d[c*DATA_W +: DATA_W]  = hold_d[c];
      end
    end

    init_hit = (int'(init_addr) >= BASE_ADDR) && (int'(init_addr) < MEM_END);
    init_off = MEM_AW'(int'(init_addr) - BASE_ADDR);
  end

  // NOTE: the memory array has no reset; its contents survive reset assertion.
  // Later assignments win, so ascending channel order then the backdoor gives
  // highest-channel-wins with backdoor priority over all.
  always_ff @(posedge clock) begin
    for (int c = 0; c < N_CH; c++) begin
      if (wr_acc[c]) begin
        for (int j = 0; j < NB_MAX; j++) begin
          if (j < wr_nb[c]) mem_q[wr_off[c] + MEM_AW'(j)] <= Mout_Wdata_ram[c*DATA_W + j*8 +: 8];
        end
      end
    end
    if (init_we && init_hit) mem_q[init_off] <= init_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
        hold_q[c]  <= '0;
      end
      rdata_q     <= '0;
      rdy_q       <= '0;
      err_both_q  <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        hold_q[c]  <= hold_d[c];
      end
      rdata_q     <= rdata_d;
      rdy_q       <= rdy_d;
      err_both_q  <= err_both_q | both_hit;
      err_range_q <= err_range_q | range_hit;
    end
  end

  assign M_Rdata_ram = rdata_q;
  assign M_DataRdy   = rdy_q;
  assign err_both    = err_both_q;
  assign err_range   = err_range_q;

endmodule

// File: tb/tb_ext_mem_model_mc.sv
// Bench for ext_mem_model_mc: vector table of accesses scored through a response
// queue, plus hand-written collision, range, protocol and reset sequences.
module tb_ext_mem_model_mc;

  localparam int RD = 2;
  localparam int WR = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  oe = '0, we = '0;
  logic [15:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [11:0] size = '0;
  logic        init_we = 1'b0;
  logic [7:0]  init_addr = '0, init_data = '0;

  logic [63:0] rdata, rdata4;
  logic [1:0]  rdy, rdy4;
  logic        eb, er, eb4, er4;

  always #5 clk = ~clk;

  ext_mem_model_mc dut (
    .clock(clk), .reset(rst_n),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .err_both(eb), .err_range(er)
  );

  ext_mem_model_mc #(.READ_DELAY(4)) dut4 (
    .clock(clk), .reset(rst_n),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata4), .M_DataRdy(rdy4),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .err_both(eb4), .err_range(er4)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          ch;
    bit          wr;
    logic [7:0]  a;
    logic [5:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expectation for its channel.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        if (rdy[c]) begin
          int found;
          found = -1;
          for (int i = 0; i < sb.size(); i++) if (found < 0 && sb[i].ch == c) found = i;
          if (found < 0) begin
            check(1'b0, $sformatf("unexpected_rdy_ch%0d", c), 64'(cyc), 64'(0));
          end else begin
            exp_t e;
            e = sb[found];
            sb.delete(found);
            check(cyc == e.cyc, $sformatf("rdy_cycle_ch%0d", c), 64'(cyc), 64'(e.cyc));
            if (e.chk) check(rdata[c*32 +: 32] == e.data, $sformatf("rdata_ch%0d", c),
                             64'(rdata[c*32 +: 32]), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic drive(input int ch, input bit r, input bit w, input logic [7:0] a,
                       input logic [5:0] sz, input logic [31:0] wd);
    oe[ch] = r;
    we[ch] = w;
    addr[ch*8 +: 8]   = a;
    size[ch*6 +: 6]   = sz;
    wdata[ch*32 +: 32] = wd;
  endtask

  task automatic idle_ch(input int ch);
    oe[ch] = 1'b0;
    we[ch] = 1'b0;
  endtask

  task automatic expect_rsp(input int ch, input bit chk, input logic [31:0] d, input int lat);
    sb.push_back('{ch: ch, data: d, chk: chk, cyc: cyc + lat});
  endtask

  // Called right after a falling edge; holds the request through the RESP cycle.
  task automatic access(input vec_t v);
    int d;
    d = v.wr ? WR : RD;
    drive(v.ch, !v.wr, v.wr, v.a, v.sz, v.wd);
    expect_rsp(v.ch, !v.wr, v.exp, d);
    repeat (d + 1) @(negedge clk);
    idle_ch(v.ch);
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  vec_t vt[13];
  bit   saw;

  initial begin
    vt[0]  = '{0, 1'b1, 8'h10, 6'd32, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1, 1'b0, 8'h10, 6'd32, 32'h0,        32'hDEADBEEF};
    vt[2]  = '{1, 1'b0, 8'h10, 6'd32, 32'h0,        32'h44332211};
    vt[3]  = '{0, 1'b1, 8'h11, 6'd8,  32'h123456AA, 32'h0};
    vt[4]  = '{1, 1'b0, 8'h10, 6'd32, 32'h0,        32'h4433AA11};
    vt[5]  = '{0, 1'b0, 8'h10, 6'd16, 32'h0,        32'h0000AA11};
    vt[6]  = '{1, 1'b0, 8'h13, 6'd8,  32'h0,        32'h00000044};
    vt[7]  = '{0, 1'b0, 8'h10, 6'd0,  32'h0,        32'h4433AA11};
    vt[8]  = '{0, 1'b1, 8'h7C, 6'd32, 32'hCAFEF00D, 32'h0};
    vt[9]  = '{1, 1'b0, 8'h7C, 6'd32, 32'h0,        32'hCAFEF00D};
    vt[10] = '{1, 1'b1, 8'h12, 6'd16, 32'hFFFF9988, 32'h0};
    vt[11] = '{0, 1'b0, 8'h10, 6'd32, 32'h0,        32'h9988AA11};
    vt[12] = '{0, 1'b0, 8'h10, 6'd40, 32'h0,        32'h9988AA11};

    repeat (3) @(negedge clk);
    check(rdata == 64'h0, "reset_rdata", rdata, 64'h0);
    check(rdy == 2'b00, "reset_rdy", 64'(rdy), 64'h0);
    check(eb == 1'b0, "reset_err_both", 64'(eb), 64'h0);
    check(er == 1'b0, "reset_err_range", 64'(er), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (i == 2) begin
        preload(8'h10, 8'h11); preload(8'h11, 8'h22);
        preload(8'h12, 8'h33); preload(8'h13, 8'h44);
      end
      access(vt[i]);
    end

    // Same-edge collision: highest channel wins.
    preload(8'h21, 8'h55);
    drive(0, 1'b0, 1'b1, 8'h20, 6'd8, 32'h01);
    drive(1, 1'b0, 1'b1, 8'h20, 6'd8, 32'h02);
    expect_rsp(0, 1'b0, 32'h0, WR);
    expect_rsp(1, 1'b0, 32'h0, WR);
    repeat (2) @(negedge clk);
    idle_ch(0); idle_ch(1);
    @(negedge clk);
    access('{0, 1'b0, 8'h20, 6'd8, 32'h0, 32'h02});

    // Read of a byte written by the other channel at the same edge sees old data.
    drive(0, 1'b1, 1'b0, 8'h21, 6'd8, 32'h0);
    drive(1, 1'b0, 1'b1, 8'h21, 6'd8, 32'h66);
    expect_rsp(0, 1'b1, 32'h55, RD);
    expect_rsp(1, 1'b0, 32'h0, WR);
    repeat (2) @(negedge clk);
    idle_ch(1);
    @(negedge clk);
    idle_ch(0);
    @(negedge clk);
    access('{0, 1'b0, 8'h21, 6'd8, 32'h0, 32'h66});

    // Backdoor beats a channel write to the same byte.
    init_we = 1'b1; init_addr = 8'h22; init_data = 8'h77;
    drive(1, 1'b0, 1'b1, 8'h22, 6'd8, 32'h88);
    expect_rsp(1, 1'b0, 32'h0, WR);
    @(negedge clk);
    init_we = 1'b0;
    @(negedge clk);
    idle_ch(1);
    @(negedge clk);
    access('{0, 1'b0, 8'h22, 6'd8, 32'h0, 32'h77});

    // Fully outside: ignored silently.
    drive(0, 1'b1, 1'b0, 8'd128, 6'd32, 32'h0);
    repeat (4) @(negedge clk);
    check(rdy[0] == 1'b0 && rdata[31:0] == 32'h0, "outside_no_rsp", rdata[31:0], 64'h0);
    idle_ch(0);
    @(negedge clk);
    check(er == 1'b0, "outside_no_err", 64'(er), 64'h0);

    // Partially outside: ignored, sticky range error.
    drive(0, 1'b1, 1'b0, 8'd126, 6'd32, 32'h0);
    repeat (4) @(negedge clk);
    idle_ch(0);
    @(negedge clk);
    check(er == 1'b1, "partial_err_range", 64'(er), 64'h1);
    repeat (5) @(negedge clk);
    check(er == 1'b1, "partial_err_sticky", 64'(er), 64'h1);
    check(eb == 1'b0, "err_both_still_clear", 64'(eb), 64'h0);

    // oe and we together on ch1 for one cycle.
    drive(1, 1'b1, 1'b1, 8'h10, 6'd32, 32'h0);
    @(negedge clk);
    idle_ch(1);
    repeat (4) @(negedge clk);
    check(eb == 1'b1, "err_both_set", 64'(eb), 64'h1);
    repeat (5) @(negedge clk);
    check(eb == 1'b1, "err_both_sticky", 64'(eb), 64'h1);

    check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'h0);
    while (sb.size() > 0) void'(sb.pop_front());

    // Reset mid-access (dut4 has READ_DELAY=4; dut is in RESP at the reset point).
    mon_en = 1'b0;
    preload(8'h40, 8'hA1); preload(8'h41, 8'hB2);
    preload(8'h42, 8'hC3); preload(8'h43, 8'hD4);
    repeat (6) @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h40, 6'd32, 32'h0);
    repeat (2) @(negedge clk);
    check(rdy[0] == 1'b1 && rdata[31:0] == 32'hD4C3B2A1, "pre_reset_rsp", rdata[31:0], 64'hD4C3B2A1);
    idle_ch(0);
    rst_n = 1'b0;
    #1;
    check(rdata == 64'h0 && rdy == 2'b00, "reset_clears_outputs", rdata, 64'h0);
    check(eb == 1'b0 && er == 1'b0, "reset_clears_errors", 64'({eb, er}), 64'h0);
    check(rdata4 == 64'h0 && rdy4 == 2'b00, "reset_clears_dut4", rdata4, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdy4 != 2'b00 || rdy != 2'b00) saw = 1'b1;
    end
    check(!saw, "no_rsp_after_reset", 64'(saw), 64'h0);

    drive(0, 1'b1, 1'b0, 8'h40, 6'd32, 32'h0);
    repeat (4) @(negedge clk);
    check(rdy4[0] == 1'b1 && rdata4[31:0] == 32'hD4C3B2A1, "mem_kept_over_reset",
          rdata4[31:0], 64'hD4C3B2A1);
    idle_ch(0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
